core_operand_fetch: RTL and testbench

- Initiator-side counterpart of core_regfile: drives both regfile read ports (rs0/rs1) and the write port (rd) on behalf of the pipeline.
- Accepts decoded instructions and issues register reads, returning the operand pair downstream with valid/ready.
- Routes writeback traffic into the regfile.
- A 32-entry scoreboard blocks RAW/WAW hazards against pending writebacks.

---
 rtl/core_regfile_pkg.sv | 30 +++
 rtl/core_operand_fetch_if.sv | 62 ++++++
 rtl/core_scoreboard.sv | 48 ++++
 rtl/core_operand_fetch.sv | 180 ++++++++++++++++++
 tb/tb_core_operand_fetch.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_regfile_pkg
// Description : Shared constants, types and the operand-fetch state encoding
//               used by core_operand_fetch and its scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package core_regfile_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = $clog2(NREG);

   typedef logic [AW-1:0]   reg_addr_t;
   typedef logic [XLEN-1:0] xlen_t;
   typedef logic [NREG-1:0] sb_vec_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } opf_state_e;

   // A source only carries a real dependency when it is used and is not x0.
   function automatic logic is_live_src(input logic used, input reg_addr_t addr);
      return used & (addr != '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/core_operand_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : core_operand_fetch_if
// Description : Issue, regfile read/write, writeback and operand-out signals
//               of the operand-fetch unit. slave = fetch unit view,
//               master = pipeline / regfile environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_operand_fetch_if;
   import core_regfile_pkg::*;

   // issue side
   logic      iss_valid_i;
   logic      iss_ready_o;
   logic      iss_rs0_use_i;
   logic      iss_rs1_use_i;
   reg_addr_t iss_rs0_addr_i;
   reg_addr_t iss_rs1_addr_i;
   logic      iss_rd_we_i;
   reg_addr_t iss_rd_addr_i;
   // regfile read ports
   logic      rs0_re_o;
   logic      rs1_re_o;
   reg_addr_t rs0_addr_o;
   reg_addr_t rs1_addr_o;
   xlen_t     rs0_data_i;
   xlen_t     rs1_data_i;
   // writeback in, regfile write port out
   logic      wb_valid_i;
   reg_addr_t wb_addr_i;
   xlen_t     wb_data_i;
   logic      rd_we_o;
   reg_addr_t rd_addr_o;
   xlen_t     rd_data_o;
   // operand output
   logic      op_valid_o;
   logic      op_ready_i;
   xlen_t     op_rs0_data_o;
   xlen_t     op_rs1_data_o;
   logic      op_rd_we_o;
   reg_addr_t op_rd_addr_o;

   modport slave (
      input  iss_valid_i, iss_rs0_use_i, iss_rs1_use_i, iss_rs0_addr_i,
             iss_rs1_addr_i, iss_rd_we_i, iss_rd_addr_i,
             rs0_data_i, rs1_data_i, wb_valid_i, wb_addr_i, wb_data_i, op_ready_i,
      output iss_ready_o, rs0_re_o, rs1_re_o, rs0_addr_o, rs1_addr_o,
             rd_we_o, rd_addr_o, rd_data_o,
             op_valid_o, op_rs0_data_o, op_rs1_data_o, op_rd_we_o, op_rd_addr_o
   );

   modport master (
      output iss_valid_i, iss_rs0_use_i, iss_rs1_use_i, iss_rs0_addr_i,
             iss_rs1_addr_i, iss_rd_we_i, iss_rd_addr_i,
             rs0_data_i, rs1_data_i, wb_valid_i, wb_addr_i, wb_data_i, op_ready_i,
      input  iss_ready_o, rs0_re_o, rs1_re_o, rs0_addr_o, rs1_addr_o,
             rd_we_o, rd_addr_o, rd_data_o,
             op_valid_o, op_rs0_data_o, op_rs1_data_o, op_rd_we_o, op_rd_addr_o
   );

endinterface
`default_nettype wire

// File: rtl/core_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : core_scoreboard
// Description : One pending bit per architectural register. Set on issue of a
//               writing instruction, cleared on writeback; set beats clear on
//               the same register, and x0 is never pending.
// Revision    : 1.0 - initial release
// ============================================================================
module core_scoreboard
   import core_regfile_pkg::*;
(
   input  wire logic      clk_i,
   input  wire logic      rst_i,
   input  wire logic      set_i,
   input  wire reg_addr_t set_addr_i,
   input  wire logic      clr_i,
   input  wire reg_addr_t clr_addr_i,
   input  wire reg_addr_t rs0_addr_i,
   input  wire reg_addr_t rs1_addr_i,
   input  wire reg_addr_t rd_addr_i,
   output logic           rs0_pend_o,
   output logic           rs1_pend_o,
   output logic           rd_pend_o
);

   sb_vec_t sb_q;
   sb_vec_t sb_d;

   // Next pending vector: clear first so a same-register set overrides it.
   always_comb begin
      sb_d = sb_q;
      if (clr_i) sb_d[clr_addr_i] = 1'b0;
      if (set_i) sb_d[set_addr_i] = 1'b1;
      sb_d[0] = 1'b0;
   end

   // Pending vector register.
   always_ff @(posedge clk_i) begin
      if (rst_i) sb_q <= '0;
      else       sb_q <= sb_d;
   end

   assign rs0_pend_o = sb_q[rs0_addr_i];
   assign rs1_pend_o = sb_q[rs1_addr_i];
   assign rd_pend_o  = sb_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/core_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : core_operand_fetch
// Description : Accepts decoded instructions, reads both source registers from
//               the regfile, and presents the operand pair downstream with a
//               valid/ready handshake. Forwards writebacks to the regfile write
//               port and blocks RAW/WAW hazards through a scoreboard.
//               Optional macro CORE_OPFETCH_BYPASS_EN: a writeback landing in
//               the issue cycle unblocks its register and its data is bypassed
//               into the operand instead of the stale regfile read.
// Revision    : 1.0 - initial release
// ============================================================================
module core_operand_fetch
   import core_regfile_pkg::*;
(
   input wire logic           clk_i,
   input wire logic           rst_i,
   core_operand_fetch_if.slave bus
);

   opf_state_e state_q, state_d;

   logic      live0, live1;
   logic      pend0, pend1, pendrd;
   logic      blk0, blk1, blkrd;
   logic      hazard, iss_ready, fire;

   logic      live0_q, live1_q;
   logic      rd_we_q;
   reg_addr_t rd_addr_q;
   xlen_t     src0, src1;
   xlen_t     fetch0, fetch1;
   xlen_t     hold0_q, hold1_q;
   logic      op_valid;
   xlen_t     op0, op1;

   assign live0 = is_live_src(bus.iss_rs0_use_i, bus.iss_rs0_addr_i);
   assign live1 = is_live_src(bus.iss_rs1_use_i, bus.iss_rs1_addr_i);

   core_scoreboard u_sb (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .set_i      (fire & bus.iss_rd_we_i),
      .set_addr_i (bus.iss_rd_addr_i),
      .clr_i      (bus.wb_valid_i),
      .clr_addr_i (bus.wb_addr_i),
      .rs0_addr_i (bus.iss_rs0_addr_i),
      .rs1_addr_i (bus.iss_rs1_addr_i),
      .rd_addr_i  (bus.iss_rd_addr_i),
      .rs0_pend_o (pend0),
      .rs1_pend_o (pend1),
      .rd_pend_o  (pendrd)
   );

`ifdef CORE_OPFETCH_BYPASS_EN
   logic  wbhit0, wbhit1, wbhitrd;
   logic  byp0_q, byp1_q;
   xlen_t byp0_data_q, byp1_data_q;

   assign wbhit0  = bus.wb_valid_i & (bus.wb_addr_i == bus.iss_rs0_addr_i);
   assign wbhit1  = bus.wb_valid_i & (bus.wb_addr_i == bus.iss_rs1_addr_i);
   assign wbhitrd = bus.wb_valid_i & (bus.wb_addr_i == bus.iss_rd_addr_i);

   // A writeback arriving this cycle retires the pending write it matches.
   assign blk0  = live0 & pend0 & ~wbhit0;
   assign blk1  = live1 & pend1 & ~wbhit1;
   assign blkrd = bus.iss_rd_we_i & pendrd & ~wbhitrd;

   // Capture same-cycle writeback data for sources that the regfile read misses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         byp0_q      <= 1'b0;
         byp1_q      <= 1'b0;
         byp0_data_q <= '0;
         byp1_data_q <= '0;
      end else if (fire) begin
         byp0_q      <= live0 & wbhit0;
         byp1_q      <= live1 & wbhit1;
         byp0_data_q <= bus.wb_data_i;
         byp1_data_q <= bus.wb_data_i;
      end
   end

   assign src0 = byp0_q ? byp0_data_q : bus.rs0_data_i;
   assign src1 = byp1_q ? byp1_data_q : bus.rs1_data_i;
`else
   assign blk0  = live0 & pend0;
   assign blk1  = live1 & pend1;
   assign blkrd = bus.iss_rd_we_i & pendrd;

   assign src0 = bus.rs0_data_i;
   assign src1 = bus.rs1_data_i;
`endif

   assign hazard    = blk0 | blk1 | blkrd;
   assign iss_ready = ((state_q == IDLE) | bus.op_ready_i) & ~hazard;
   assign fire      = bus.iss_valid_i & iss_ready;

   assign bus.iss_ready_o = iss_ready;
   assign bus.rs0_re_o    = fire & bus.iss_rs0_use_i;
   assign bus.rs1_re_o    = fire & bus.iss_rs1_use_i;
   assign bus.rs0_addr_o  = bus.iss_rs0_addr_i;
   assign bus.rs1_addr_o  = bus.iss_rs1_addr_i;

   assign bus.rd_we_o   = bus.wb_valid_i & (bus.wb_addr_i != '0);
   assign bus.rd_addr_o = bus.wb_addr_i;
   assign bus.rd_data_o = bus.wb_data_i;

   // x0 and unused sources read as zero regardless of what the regfile returns.
   assign fetch0 = live0_q ? src0 : '0;
   assign fetch1 = live1_q ? src1 : '0;

   // Per-op side information latched on fire and held until the next fire.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         live0_q   <= 1'b0;
         live1_q   <= 1'b0;
         rd_we_q   <= 1'b0;
         rd_addr_q <= '0;
      end else if (fire) begin
         live0_q   <= live0;
         live1_q   <= live1;
         rd_we_q   <= bus.iss_rd_we_i;
         rd_addr_q <= bus.iss_rd_addr_i;
      end
   end

   // Freeze the live operands when downstream stalls, since regfile data is
   // only valid in the cycle right after the read.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold0_q <= '0;
         hold1_q <= '0;
      end else if ((state_q == FETCH) && !bus.op_ready_i) begin
         hold0_q <= fetch0;
         hold1_q <= fetch1;
      end
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state and operand output selection.
   always_comb begin
      state_d  = state_q;
      op_valid = 1'b0;
      op0      = '0;
      op1      = '0;
      case (state_q)
         IDLE: begin
            if (fire) state_d = FETCH;
         end
         FETCH: begin
            op_valid = 1'b1;
            op0      = fetch0;
            op1      = fetch1;
            if (bus.op_ready_i) state_d = fire ? FETCH : IDLE;
            else                state_d = HOLD;
         end
         HOLD: begin
            op_valid = 1'b1;
            op0      = hold0_q;
            op1      = hold1_q;
            if (bus.op_ready_i) state_d = fire ? FETCH : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.op_valid_o    = op_valid;
   assign bus.op_rs0_data_o = op0;
   assign bus.op_rs1_data_o = op1;
   assign bus.op_rd_we_o    = op_valid & rd_we_q;
   assign bus.op_rd_addr_o  = op_valid ? rd_addr_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_core_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_operand_fetch
// Description : Self-checking bench for core_operand_fetch with a simple
//               regfile environment, directed sequences, a vector table and
//               a randomized phase against a queue-based reference model.
//               Honours CORE_OPFETCH_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_operand_fetch;
   import core_regfile_pkg::*;

`ifdef CORE_OPFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   core_operand_fetch_if bus ();

   core_operand_fetch dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Regfile environment: synchronous write, registered read; data is noise
   // in any cycle not preceded by a read enable. x0 storage holds junk.
   xlen_t mem [NREG];
   always @(posedge clk) begin
      if (rst) mem[0] <= 32'hBAD0_0000;
      if (bus.rd_we_o) mem[bus.rd_addr_o] <= bus.rd_data_o;
      bus.rs0_data_i <= bus.rs0_re_o ? mem[bus.rs0_addr_o] : xlen_t'($urandom);
      bus.rs1_data_i <= bus.rs1_re_o ? mem[bus.rs1_addr_o] : xlen_t'($urandom);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic set_iss(input bit v, input bit u0, input int a0, input bit u1,
                          input int a1, input bit we, input int rd);
      bus.iss_valid_i    = v;
      bus.iss_rs0_use_i  = u0;
      bus.iss_rs0_addr_i = reg_addr_t'(a0);
      bus.iss_rs1_use_i  = u1;
      bus.iss_rs1_addr_i = reg_addr_t'(a1);
      bus.iss_rd_we_i    = we;
      bus.iss_rd_addr_i  = reg_addr_t'(rd);
   endtask

   task automatic set_wb(input bit v, input int a, input xlen_t d);
      bus.wb_valid_i = v;
      bus.wb_addr_i  = reg_addr_t'(a);
      bus.wb_data_i  = d;
   endtask

   function automatic xlen_t val(input int i);
      return 32'hA500_0000 | xlen_t'(i * 32'h111);
   endfunction

   typedef struct {
      bit    u0;
      int    a0;
      bit    u1;
      int    a1;
      xlen_t e0;
      xlen_t e1;
   } vec_t;

   typedef struct {
      xlen_t     d0;
      xlen_t     d1;
      bit        we;
      reg_addr_t rd;
   } op_t;

   initial begin
      vec_t  tbl [8];
      op_t   q [$];
      bit    pend [NREG];
      int    lat;

      tbl[0] = '{1'b1, 1,  1'b1, 2,  val(1),  val(2)};
      tbl[1] = '{1'b1, 31, 1'b1, 30, val(31), val(30)};
      tbl[2] = '{1'b0, 4,  1'b1, 4,  32'h0,   val(4)};
      tbl[3] = '{1'b1, 0,  1'b1, 17, 32'h0,   val(17)};
      tbl[4] = '{1'b1, 8,  1'b0, 8,  val(8),  32'h0};
      tbl[5] = '{1'b0, 0,  1'b0, 0,  32'h0,   32'h0};
      tbl[6] = '{1'b1, 16, 1'b1, 16, val(16), val(16)};
      tbl[7] = '{1'b1, 3,  1'b1, 0,  val(3),  32'h0};

      set_iss(0, 0, 0, 0, 0, 0, 0);
      set_wb(0, 0, 0);
      bus.op_ready_i = 1'b1;

      // ---- reset state ----
      repeat (3) next();
      chk("rst_op_valid", bus.op_valid_o, 0);
      chk("rst_op_rs0", bus.op_rs0_data_o, 0);
      chk("rst_op_rd_we", bus.op_rd_we_o, 0);
      chk("rst_op_rd_addr", bus.op_rd_addr_o, 0);
      chk("rst_iss_ready", bus.iss_ready_o, 1);
      rst = 1'b0;

      // ---- preload regfile through the writeback path ----
      for (int i = 1; i < NREG; i++) begin
         next();
         set_wb(1, i, val(i));
         #1;
         if (i == 1) begin
            chk("wb_rd_we", bus.rd_we_o, 1);
            chk("wb_rd_addr", bus.rd_addr_o, 1);
            chk("wb_rd_data", bus.rd_data_o, val(1));
         end
      end

      // ---- table vectors, issued back to back ----
      for (int k = 0; k <= 8; k++) begin
         next();
         set_wb(0, 0, 0);
         if (k < 8) set_iss(1, tbl[k].u0, tbl[k].a0, tbl[k].u1, tbl[k].a1, 0, 0);
         else       set_iss(0, 0, 0, 0, 0, 0, 0);
         #1;
         if (k < 8) begin
            chk("tbl_ready", bus.iss_ready_o, 1);
            chk("tbl_re0", bus.rs0_re_o, tbl[k].u0);
         end
         if (k > 0) begin
            chk("tbl_valid", bus.op_valid_o, 1);
            chk("tbl_rs0", bus.op_rs0_data_o, tbl[k-1].e0);
            chk("tbl_rs1", bus.op_rs1_data_o, tbl[k-1].e1);
         end
      end

      // ---- basic read of 5/6 ----
      next(); set_wb(1, 5, 32'h11);
      next(); set_wb(1, 6, 32'h22);
      next(); set_wb(0, 0, 0); set_iss(1, 1, 5, 1, 6, 0, 0);
      #1;
      chk("b_ready", bus.iss_ready_o, 1);
      chk("b_re0", bus.rs0_re_o, 1);
      chk("b_re1", bus.rs1_re_o, 1);
      chk("b_addr0", bus.rs0_addr_o, 5);
      chk("b_addr1", bus.rs1_addr_o, 6);
      chk("b_valid_early", bus.op_valid_o, 0);
      next(); set_iss(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("b_valid", bus.op_valid_o, 1);
      chk("b_rs0", bus.op_rs0_data_o, 32'h11);
      chk("b_rs1", bus.op_rs1_data_o, 32'h22);
      chk("b_re0_off", bus.rs0_re_o, 0);

      // ---- RAW on r7 ----
      next(); set_iss(1, 0, 0, 0, 0, 1, 7);
      #1;
      chk("raw_wr_ready", bus.iss_ready_o, 1);
      next(); set_iss(1, 1, 7, 0, 0, 0, 0);
      #1;
      chk("raw_op_rd_we", bus.op_rd_we_o, 1);
      chk("raw_op_rd_addr", bus.op_rd_addr_o, 7);
      chk("raw_stall0", bus.iss_ready_o, 0);
      next();
      #1;
      chk("raw_stall1", bus.iss_ready_o, 0);
      next(); set_wb(1, 7, 32'hDEAD);
      #1;
      chk("raw_wb_ready", bus.iss_ready_o, BYP);
      lat = -1;
      for (int n = 0; n < 4; n++) begin
         if (n > 0) begin
            next(); set_wb(0, 0, 0);
            #1;
         end
         if (bus.iss_ready_o) begin
            lat = n;
            break;
         end
      end
      chk("raw_fire_lat", lat, BYP ? 0 : 1);
      next(); set_wb(0, 0, 0); set_iss(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("raw_valid", bus.op_valid_o, 1);
      chk("raw_rs0", bus.op_rs0_data_o, 32'hDEAD);

      // ---- downstream stall, HOLD ----
      next(); set_iss(1, 1, 5, 1, 6, 0, 0); bus.op_ready_i = 1'b0;
      #1;
      chk("h_fire", bus.iss_ready_o, 1);
      next(); set_iss(1, 1, 6, 1, 5, 0, 0);
      #1;
      chk("h_ready0", bus.iss_ready_o, 0);
      chk("h_rs0_a", bus.op_rs0_data_o, 32'h11);
      for (int n = 0; n < 2; n++) begin
         next();
         #1;
         chk("h_valid", bus.op_valid_o, 1);
         chk("h_rs0", bus.op_rs0_data_o, 32'h11);
         chk("h_rs1", bus.op_rs1_data_o, 32'h22);
         chk("h_ready", bus.iss_ready_o, 0);
      end
      next(); bus.op_ready_i = 1'b1;
      #1;
      chk("h_release_ready", bus.iss_ready_o, 1);
      chk("h_release_rs1", bus.op_rs1_data_o, 32'h22);
      next(); set_iss(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("h_next_rs0", bus.op_rs0_data_o, 32'h22);
      chk("h_next_rs1", bus.op_rs1_data_o, 32'h11);
      next();
      #1;
      chk("h_idle", bus.op_valid_o, 0);

      // ---- x0 handling ----
      set_iss(1, 1, 0, 1, 0, 1, 0);
      #1;
      chk("x0_ready", bus.iss_ready_o, 1);
      next(); set_iss(1, 0, 0, 0, 0, 1, 0); set_wb(1, 0, 32'h1234);
      #1;
      chk("x0_rs0", bus.op_rs0_data_o, 0);
      chk("x0_rs1", bus.op_rs1_data_o, 0);
      chk("x0_waw_ready", bus.iss_ready_o, 1);
      chk("x0_wb_we", bus.rd_we_o, 0);
      next(); set_iss(0, 0, 0, 0, 0, 0, 0); set_wb(0, 0, 0);

      // ---- set beats clear on r9 ----
      next(); set_iss(1, 0, 0, 0, 0, 1, 9); set_wb(1, 9, 32'h9999);
      #1;
      chk("sc_ready", bus.iss_ready_o, 1);
      next(); set_iss(1, 1, 9, 0, 0, 0, 0); set_wb(0, 0, 0);
      #1;
      chk("sc_stall0", bus.iss_ready_o, 0);
      next();
      #1;
      chk("sc_stall1", bus.iss_ready_o, 0);

      // ---- reset while in HOLD with r3, r9 pending ----
      next(); set_iss(1, 0, 0, 0, 0, 1, 3); bus.op_ready_i = 1'b0;
      #1;
      chk("rh_fire", bus.iss_ready_o, 1);
      next(); set_iss(0, 0, 0, 0, 0, 0, 0);
      next();
      #1;
      chk("rh_hold_valid", bus.op_valid_o, 1);
      chk("rh_hold_rd", bus.op_rd_addr_o, 3);
      rst = 1'b1;
      next(); rst = 1'b0; set_iss(1, 1, 9, 0, 0, 1, 3); bus.op_ready_i = 1'b1;
      #1;
      chk("rh_valid", bus.op_valid_o, 0);
      chk("rh_rd_we", bus.op_rd_we_o, 0);
      chk("rh_ready", bus.iss_ready_o, 1);
      next(); set_iss(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rh_rs0", bus.op_rs0_data_o, 32'h9999);

      // ---- randomized phase against the reference model ----
      rst = 1'b1;
      next(); next();
      rst = 1'b0;
      for (int i = 0; i < NREG; i++) pend[i] = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         bit        iv, u0, u1, we, wv, opr, ev, er, f, haz;
         int        a0, a1, rd, wa;
         xlen_t     wd;
         op_t       o;
         next();
         iv  = ($urandom_range(0, 9) < 7);
         u0  = 1'($urandom_range(0, 1));
         u1  = 1'($urandom_range(0, 1));
         a0  = $urandom_range(0, 7);
         a1  = $urandom_range(0, 7);
         we  = 1'($urandom_range(0, 1));
         rd  = $urandom_range(0, 7);
         wv  = ($urandom_range(0, 9) < 4);
         wa  = $urandom_range(0, 7);
         wd  = xlen_t'($urandom);
         opr = ($urandom_range(0, 9) < 7);
         set_iss(iv, u0, a0, u1, a1, we, rd);
         set_wb(wv, wa, wd);
         bus.op_ready_i = opr;
         #1;
         ev = (q.size() != 0);
         chk("r_valid", bus.op_valid_o, ev);
         if (ev) begin
            chk("r_rs0", bus.op_rs0_data_o, q[0].d0);
            chk("r_rs1", bus.op_rs1_data_o, q[0].d1);
            chk("r_rd_we", bus.op_rd_we_o, q[0].we);
            chk("r_rd_addr", bus.op_rd_addr_o, q[0].rd);
         end
         haz = (u0 && a0 != 0 && pend[a0] && !(BYP && wv && wa == a0)) ||
               (u1 && a1 != 0 && pend[a1] && !(BYP && wv && wa == a1)) ||
               (we && pend[rd] && !(BYP && wv && wa == rd));
         er = (!ev || opr) && !haz;
         chk("r_ready", bus.iss_ready_o, er);
         f = iv && er;
         chk("r_re0", bus.rs0_re_o, f && u0);
         chk("r_re1", bus.rs1_re_o, f && u1);
         chk("r_wb_we", bus.rd_we_o, wv && wa != 0);
         chk("r_wb_data", bus.rd_data_o, wd);
         if (ev && opr) void'(q.pop_front());
         if (f) begin
            o.d0 = (u0 && a0 != 0) ? ((BYP && wv && wa == a0) ? wd : mem[a0]) : 32'h0;
            o.d1 = (u1 && a1 != 0) ? ((BYP && wv && wa == a1) ? wd : mem[a1]) : 32'h0;
            o.we = we;
            o.rd = reg_addr_t'(rd);
            q.push_back(o);
         end
         if (wv) pend[wa] = 1'b0;
         if (f && we && rd != 0) pend[rd] = 1'b1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
